// File: rtl/seg_display_if.sv
// Display bus between the service blocks and seg_display_arbiter.
// Everything on this bus is level-based. There is no valid/ready handshake.
interface seg_display_if;
    // Service side. Levels are sampled on every clk_osc edge:
    // - req is only acted on when the frame wraps.
    // - num*, time_num, cursor and alarm_flash are consumed per digit slot.
    logic [3:0]  req;
    logic [15:0] num0;
    logic [15:0] num1;
    logic [15:0] num2;
    logic [15:0] num3;
    logic [15:0] time_num;
    logic [3:0]  cursor;
    logic        alarm_flash;

    // Display side. All of these come straight from registers.
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [3:0]  grant;
    logic [1:0]  digit_idx;

    modport master (
        output req, num0, num1, num2, num3, time_num, cursor, alarm_flash,
        input  anode, seg, grant, digit_idx
    );

    modport slave (
        input  req, num0, num1, num2, num3, time_num, cursor, alarm_flash,
        output anode, seg, grant, digit_idx
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Shares the 4-digit active-low 7-segment display between four services and the clock,
// with frame-aligned priority arbitration, cursor blink and alarm flash.
// Optional: define DISP_LEADING_ZERO_BLANK_EN to blank a leading zero on digit 3.
module seg_display_arbiter #(
    parameter int SCAN_DIV  = 65536,
    parameter int BLINK_DIV = 8388608
) (
    input  logic         clk_osc,
    input  logic         reset,
    seg_display_if.slave disp
);

    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [6:0] SEG_ALL   = 7'b0000000;

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [1:0]         r_digit_idx;
    logic [3:0]         r_grant;
    logic [3:0]         r_anode;
    logic [6:0]         r_seg;

    logic        w_scan_tc;
    logic        w_blink_tc;
    logic        w_frame_wrap;
    logic [3:0]  w_req_low;
    logic [15:0] w_src;
    logic [3:0]  w_nibble;
    logic [3:0]  w_anode_on;
    logic        w_owned;
    logic        w_cursor_here;
    logic        w_cursor_blank;
    logic        w_lz_blank;
    logic [6:0]  w_seg_dec;
    logic [3:0]  w_anode_nxt;
    logic [6:0]  w_seg_nxt;

    // Active-low {g,f,e,d,c,b,a} patterns. Nibbles 10..15 show as blank.
    function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
        logic [6:0] v;
        case (i_nib)
            4'd0:    v = 7'b1000000;
            4'd1:    v = 7'b1111001;
            4'd2:    v = 7'b0100100;
            4'd3:    v = 7'b0110000;
            4'd4:    v = 7'b0011001;
            4'd5:    v = 7'b0010010;
            4'd6:    v = 7'b0000010;
            4'd7:    v = 7'b1111000;
            4'd8:    v = 7'b0000000;
            4'd9:    v = 7'b0010000;
            default: v = 7'b1111111;
        endcase
        return v;
    endfunction

    assign w_scan_tc    = (r_scan_cnt == SCAN_LAST);
    assign w_blink_tc   = (r_blink_cnt == BLINK_LAST);
    assign w_frame_wrap = w_scan_tc && (r_digit_idx == 2'd3);
    // Isolate the lowest set request bit. Bit 0 has the highest priority.
    assign w_req_low    = disp.req & (~disp.req + 4'd1);

    // Scan counter, digit slot and owner. The owner changes only on the 3->0 wrap.
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 2'd0;
            r_grant     <= 4'b0000;
        end else if (w_scan_tc) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 2'd1;
            if (w_frame_wrap) begin
                r_grant <= w_req_low;
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Blink timebase. It runs independently of the scan.
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_tc) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    always_comb begin
        w_src = disp.time_num;
        case (r_grant)
            4'b0001: w_src = disp.num0;
            4'b0010: w_src = disp.num1;
            4'b0100: w_src = disp.num2;
            4'b1000: w_src = disp.num3;
            default: w_src = disp.time_num;
        endcase
    end

    always_comb begin
        w_nibble = w_src[3:0];
        case (r_digit_idx)
            2'd0: w_nibble = w_src[3:0];
            2'd1: w_nibble = w_src[7:4];
            2'd2: w_nibble = w_src[11:8];
            2'd3: w_nibble = w_src[15:12];
            default: w_nibble = w_src[3:0];
        endcase
    end

    assign w_anode_on     = ~(4'b0001 << r_digit_idx);
    assign w_owned        = (r_grant != 4'b0000);
    assign w_cursor_here  = disp.cursor[r_digit_idx];
    assign w_cursor_blank = w_owned && w_cursor_here && r_blink_phase;
    assign w_seg_dec      = f_decode(w_nibble);

`ifdef DISP_LEADING_ZERO_BLANK_EN
    // A zero being edited on digit 3 must stay visible, so the cursor wins.
    assign w_lz_blank = (r_digit_idx == 2'd3) && (w_nibble == 4'd0) &&
                        !(w_owned && disp.cursor[3]);
`else
    assign w_lz_blank = 1'b0;
`endif

    // Alarm flash takes precedence over cursor blink and leading-zero blanking.
    always_comb begin
        w_anode_nxt = w_anode_on;
        w_seg_nxt   = w_seg_dec;
        if (disp.alarm_flash) begin
            if (r_blink_phase) begin
                w_anode_nxt = ANODE_OFF;
                w_seg_nxt   = SEG_OFF;
            end else begin
                w_anode_nxt = w_anode_on;
                w_seg_nxt   = SEG_ALL;
            end
        end else if (w_cursor_blank || w_lz_blank) begin
            w_anode_nxt = ANODE_OFF;
            w_seg_nxt   = SEG_OFF;
        end
    end

    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            r_anode <= ANODE_OFF;
            r_seg   <= SEG_OFF;
        end else begin
            r_anode <= w_anode_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign disp.anode     = r_anode;
    assign disp.seg       = r_seg;
    assign disp.grant     = r_grant;
    assign disp.digit_idx = r_digit_idx;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with short scan/blink dividers.
// A cycle-count model gives expected outputs, and a decode table checks the segment patterns.
module tb_seg_display_arbiter;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic clk_osc = 1'b0;
  logic reset   = 1'b1;

  seg_display_if disp();

  seg_display_arbiter #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_osc (clk_osc),
    .reset   (reset),
    .disp    (disp)
  );

  always #5 clk_osc = ~clk_osc;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the number of active edges since reset released, and the owner.
  int         k = 0;
  logic [3:0] m_grant = 4'b0000;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;
  dec_vec_t dec_tbl[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  // The segment letters lit for each decimal digit. Active-low, so a lit segment is 0.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    string s;
    logic [6:0] v;
    int b;
    case (n)
      4'd0: s = "abcdef";
      4'd1: s = "bc";
      4'd2: s = "abdeg";
      4'd3: s = "abcdg";
      4'd4: s = "bcfg";
      4'd5: s = "acdfg";
      4'd6: s = "acdefg";
      4'd7: s = "abc";
      4'd8: s = "abcdefg";
      4'd9: s = "abcdfg";
      default: s = "";
    endcase
    v = 7'h7F;
    for (int i = 0; i < s.len(); i++) begin
      b = int'(s[i]) - 97;
      v[b] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [3:0] low_bit(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  function automatic int m_digit();
    return (k / SCAN_DIV) % 4;
  endfunction

  function automatic logic m_phase();
    return ((k / BLINK_DIV) % 2) == 1;
  endfunction

  // Expected registered output for the current model state and the current inputs.
  task automatic model_out(output logic [3:0] ea, output logic [6:0] es);
    logic [15:0] src;
    logic [3:0]  nib;
    int d;
    logic p, owned, lz;
    d = m_digit();
    p = m_phase();
    owned = (m_grant != 4'b0000);
    src = disp.time_num;
    if (m_grant == 4'b0001) src = disp.num0;
    if (m_grant == 4'b0010) src = disp.num1;
    if (m_grant == 4'b0100) src = disp.num2;
    if (m_grant == 4'b1000) src = disp.num3;
    nib = src[4*d +: 4];
    lz = 1'b0;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    lz = (d == 3) && (nib == 4'd0) && !(owned && disp.cursor[3]);
`endif
    ea = 4'hF & ~4'(1 << d);
    es = seg_of(nib);
    if (disp.alarm_flash) begin
      if (p) ea = 4'hF;
      else   es = 7'b0000000;
    end else if ((owned && disp.cursor[d] && p) || lz) begin
      ea = 4'hF;
    end
  endtask

  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    model_out(ea, es);
    @(posedge clk_osc);
    k++;
    if (k % FRAME == 0) m_grant = low_bit(disp.req);
    @(negedge clk_osc);
    check("anode", 16'(disp.anode), 16'(ea));
    if (ea != 4'hF) check("seg", 16'(disp.seg), 16'(es));
    check("digit_idx", 16'(disp.digit_idx), 16'(m_digit()));
    check("grant", 16'(disp.grant), 16'(m_grant));
  endtask

  task automatic run_to_wrap();
    do step(); while (k % FRAME != 0);
  endtask

  task automatic reset_mid();
    #2;
    reset = 1'b1;
    #1;
    check("rst_anode", 16'(disp.anode), 16'h000F);
    check("rst_seg", 16'(disp.seg), 16'h007F);
    check("rst_grant", 16'(disp.grant), 16'h0000);
    check("rst_digit", 16'(disp.digit_idx), 16'h0000);
    @(negedge clk_osc);
    reset = 1'b0;
    k = 0;
    m_grant = 4'b0000;
  endtask

  initial begin
    dec_tbl[0]  = '{4'h0, 7'b1000000};
    dec_tbl[1]  = '{4'h1, 7'b1111001};
    dec_tbl[2]  = '{4'h2, 7'b0100100};
    dec_tbl[3]  = '{4'h3, 7'b0110000};
    dec_tbl[4]  = '{4'h4, 7'b0011001};
    dec_tbl[5]  = '{4'h5, 7'b0010010};
    dec_tbl[6]  = '{4'h6, 7'b0000010};
    dec_tbl[7]  = '{4'h7, 7'b1111000};
    dec_tbl[8]  = '{4'h8, 7'b0000000};
    dec_tbl[9]  = '{4'h9, 7'b0010000};
    dec_tbl[10] = '{4'hA, 7'b1111111};
    dec_tbl[11] = '{4'hB, 7'b1111111};
    dec_tbl[12] = '{4'hC, 7'b1111111};
    dec_tbl[13] = '{4'hD, 7'b1111111};
    dec_tbl[14] = '{4'hE, 7'b1111111};
    dec_tbl[15] = '{4'hF, 7'b1111111};

    disp.req = 4'b0000;
    disp.num0 = 16'h1111;
    disp.num1 = 16'h5678;
    disp.num2 = 16'h9012;
    disp.num3 = 16'h3456;
    disp.time_num = 16'h1234;
    disp.cursor = 4'b0000;
    disp.alarm_flash = 1'b0;

    // Reset is held from time zero.
    @(negedge clk_osc);
    check("init_anode", 16'(disp.anode), 16'h000F);
    check("init_seg", 16'(disp.seg), 16'h007F);
    check("init_grant", 16'(disp.grant), 16'h0000);
    check("init_digit", 16'(disp.digit_idx), 16'h0000);
    reset = 1'b0;

    // Scan of time_num 1234: anode order 1110,1101,1011,0111 showing 4,3,2,1.
    step();
    check("scan_first_anode", 16'(disp.anode), 16'h000E);
    check("scan_first_seg", 16'(disp.seg), 16'(7'b0011001));
    for (int i = 0; i < 2 * FRAME - 1; i++) step();

    // Priority deferral: raise req while digit 1 is being scanned.
    while (m_digit() != 1) step();
    disp.req = 4'b0110;
    step();
    check("defer_grant", 16'(disp.grant), 16'h0000);
    run_to_wrap();
    check("prio_grant", 16'(disp.grant), 16'h0002);
    step();
    check("prio_num1_seg", 16'(disp.seg), 16'(7'b0000000));
    while (m_digit() != 1) step();
    disp.req = 4'b0100;
    for (int i = 0; i < SCAN_DIV; i++) step();
    check("hold_grant", 16'(disp.grant), 16'h0002);
    run_to_wrap();
    check("next_grant", 16'(disp.grant), 16'h0004);

    // Cursor blink on digit 2 of service 1.
    disp.req = 4'b0001;
    disp.cursor = 4'b0100;
    run_to_wrap();
    for (int i = 0; i < 3 * FRAME; i++) step();

    // Alarm flash overrides all sources and the cursor.
    disp.alarm_flash = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step();
    disp.alarm_flash = 1'b0;

    // Decode table, driven through time_num.
    disp.req = 4'b0000;
    disp.cursor = 4'b0000;
    run_to_wrap();
    for (int t = 0; t < 16; t++) begin
      disp.time_num = {4{dec_tbl[t].nib}};
      for (int i = 0; i < SCAN_DIV; i++) step();
      if (disp.anode != 4'hF) check("decode_tbl", 16'(disp.seg), 16'(dec_tbl[t].seg));
    end

    // Leading zero on digit 3 of time 0530.
    disp.time_num = 16'h0530;
    run_to_wrap();
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (((k - 1) / SCAN_DIV) % 4 == 3) begin
`ifdef DISP_LEADING_ZERO_BLANK_EN
        check("lz_anode", 16'(disp.anode), 16'h000F);
`else
        check("lz_anode", 16'(disp.anode), 16'h0007);
        check("lz_seg", 16'(disp.seg), 16'(7'b1000000));
`endif
      end
    end

    // Randomized traffic checked by the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) disp.req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) disp.num0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) disp.num1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) disp.num2 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) disp.num3 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) disp.time_num = 16'($urandom);
      if ($urandom_range(0, 15) == 0)
        disp.cursor = ($urandom_range(0, 4) == 4) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) disp.alarm_flash = ~disp.alarm_flash;
      step();
    end

    // Reset in the middle of a frame, then scanning restarts from digit 0.
    disp.alarm_flash = 1'b0;
    disp.req = 4'b1000;
    for (int i = 0; i < 6; i++) step();
    reset_mid();
    step();
    check("post_rst_anode", 16'(disp.anode), 16'h000E);
    for (int i = 0; i < 2 * FRAME; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the single 4-digit, active-low 7-segment display between the four service blocks (time set, alarm set, stopwatch, alarm/mini-game) and the free-running current-time counter. It arbitrates display ownership by fixed priority and changes owner only at frame boundaries, so a frame never mixes two sources. It scans the anodes, decodes BCD, blinks the edit cursor digit and flashes the whole display during an alarm. It replaces the ad-hoc digit mux in the top level and sits between the service outputs and the `eSeg`/`anode` pins.

## Interface
- SCAN_DIV, 65536: `clk_osc` cycles per digit slot (≥2).
- BLINK_DIV, 8388608: `clk_osc` cycles per blink half-period (≥2).
- clk_osc  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  4  display request per service; bit 0 = service 1 (highest priority) … bit 3 = service 4
- num0, num1, num2, num3  in  16 each  4-digit BCD value of service 1..4; [3:0] = rightmost digit
- time_num  in  16  current time (BCD MM:SS), shown when no request is granted
- cursor  in  4  one-hot digit under edit for the granted service; bit 0 = rightmost digit
- alarm_flash  in  1  alarm ringing; overrides all sources
- anode  out  4  active-low digit enables; bit 0 = rightmost digit
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- grant  out  4  one-hot current owner; 0000 = time_num
- digit_idx  out  2  digit slot being driven (0 = rightmost)

## Operation
- Reset values: anode=1111, seg=1111111, grant=0000, digit_idx=0, scan counter=0, blink counter=0, blink_phase=0.
- Scan: the counter runs 0..SCAN_DIV-1. At terminal count it returns to 0 and digit_idx increments, wrapping 3→0.
- Arbitration: when digit_idx wraps 3→0, grant loads the lowest set bit of req (req=0110 → 0010), or 0000 if req=0. At all other times grant holds, including when the owner drops req mid-frame.
- Source select: the nibble is taken from the granted num (or time_num if grant=0000), bits [4*digit_idx+3 : 4*digit_idx].
- Decode: 0–9 use standard patterns (0 → 1000000, 8 → 0000000). 10–15 → 1111111 (blank).
- Blink: the blink counter runs 0..BLINK_DIV-1 and toggles blink_phase at terminal count. If grant≠0000, cursor[digit_idx]=1 and blink_phase=1, the digit is blanked (anode=1111).
- Alarm flash: when alarm_flash=1, seg is forced to 0000000 while blink_phase=0 and anode is forced to 1111 while blink_phase=1. Cursor blanking is ignored. Arbitration and scanning continue.
- Anode pattern: the enabled digit is low, for example digit_idx=2 → 1011.

## Timing
- anode and seg are registered. Both reflect the current digit_idx, grant, num*, cursor, alarm_flash and blink_phase with 1-cycle latency.
- digit_idx and grant update on the same edge. The first anode/seg output of a new frame appears one cycle later.
- num*/time_num changes are visible on the next registered output of the affected digit. There is no frame-level latching of data.
- Simultaneous req change and frame wrap: the req value sampled on the wrap edge is used.
- Counters are independent. A blink toggle coinciding with a scan step applies both.
- Reset mid-frame returns immediately to the reset values. Scanning resumes from digit 0.

## Configuration
- DISP_LEADING_ZERO_BLANK_EN defined: digit 3 is blanked when its nibble is 0. This does not apply when cursor[3]=1 with a non-zero grant, or during alarm_flash. Example: time 0530 shows as " 530".
- Not defined: all four digits are always displayed as decoded.

## Test plan
- Reset: assert reset mid-scan → anode=1111, seg=1111111, grant=0000, digit_idx=0 within the same cycle. Release → digit 0 is driven after SCAN_DIV+1 cycles at most.
- Scan, with SCAN_DIV=4, req=0, time_num=16'h1234:
  - anode cycles 1110/1011... in the order 1110, 1101, 1011, 0111, each for 4 cycles.
  - seg shows 4, 3, 2, 1 in that order.
- Priority and deferral:
  - Raise req=0110 at digit_idx=1 → grant stays 0000 until the 3→0 wrap, then becomes 0010, and num1 is shown.
  - Drop req[1] mid-frame → num1 is held until the next wrap.
- Cursor blink, with BLINK_DIV=8, req=0001, cursor=0100 → digit 2 anode is high whenever blink_phase=1. Other digits are unaffected.
- Alarm and invalid data:
  - alarm_flash=1 → seg=0000000 in phase 0 and anode=1111 in phase 1.
  - Nibble 4'hA → seg=1111111.
- Macro: with DISP_LEADING_ZERO_BLANK_EN and time_num=16'h0530, digit 3 is blank. Without the macro, digit 3 shows 1000000.
